meas_pred_dec: RTL and testbench

Decoder-side counterpart of the measurement-domain intra predictor. It accepts one block per handshake: quantized residual measurements y_resQ, a 2-bit prediction code and Qstep. It rebuilds the prediction candidate from the left, top or constant neighbour and outputs reconstructed measurements y_rec bit-exactly equal to the encoder's internal reconstruction. It sits between the entropy decoder and the CS reconstruction stage.

---
 rtl/meas_pred_dec_if.sv | 40 ++++
 rtl/meas_pred_dec.sv | 147 ++++++++++++++
 tb/tb_meas_pred_dec.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/meas_pred_dec_if.sv
// Block handshake bundle for meas_pred_dec. The err signal exists only when
// MEAS_PRED_DEC_ERR_EN is defined.
interface meas_pred_dec_if #(
  parameter int unsigned MEA_N     = 12,
  parameter int unsigned MB        = 13,
  parameter int unsigned CXW       = 6,
  parameter int unsigned CYW       = 6,
  parameter int unsigned QSTEP_WID = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [MB-1:0]    y_resQ [MEA_N];
  logic signed [1:0]       code;
  logic [QSTEP_WID-1:0]    Qstep;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [MB-1:0]    y_rec [MEA_N];
  logic [CXW-1:0]          cor_X;
  logic [CYW-1:0]          cor_Y;
  logic                    frame_done;
`ifdef MEAS_PRED_DEC_ERR_EN
  logic                    err;
`endif

  modport master (
    output in_valid, y_resQ, code, Qstep, out_ready,
    input  in_ready, out_valid, y_rec, cor_X, cor_Y, frame_done
`ifdef MEAS_PRED_DEC_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  in_valid, y_resQ, code, Qstep, out_ready,
    output in_ready, out_valid, y_rec, cor_X, cor_Y, frame_done
`ifdef MEAS_PRED_DEC_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/meas_pred_dec.sv
// Decoder-side measurement-domain intra predictor: rebuilds the candidate and dequantizes.
// Define MEAS_PRED_DEC_ERR_EN to add a sticky err output flagging overridden codes.
module meas_pred_dec #(
  parameter int unsigned BLK_N          = 4,
  parameter int unsigned PIX_WID        = 8,
  parameter int unsigned QSTEP_WID      = 3,
  parameter int unsigned PIC_WID_IN_PIX = 256,
  parameter int unsigned PIC_HT_IN_PIX  = 256
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           rst_n,
  meas_pred_dec_if.slave bus
);
  localparam int unsigned PIX_N          = BLK_N * BLK_N;
  localparam int unsigned MEA_N          = PIX_N * 3 / 4;
  localparam int unsigned MEA_WID        = $clog2(PIX_N) + PIX_WID;
  localparam int unsigned MB             = MEA_WID + 1;
  localparam int unsigned PIC_WID_IN_BLK = PIC_WID_IN_PIX / BLK_N;
  localparam int unsigned PIC_HT_IN_BLK  = PIC_HT_IN_PIX / BLK_N;
  localparam int unsigned CXW            = $clog2(PIC_WID_IN_BLK);
  localparam int unsigned CYW            = $clog2(PIC_HT_IN_BLK);
  localparam int unsigned NB_SHIFT       = 1 + $clog2(BLK_N);
  localparam logic [CXW-1:0]     X_LAST     = CXW'(PIC_WID_IN_BLK - 1);
  localparam logic [CYW-1:0]     Y_LAST     = CYW'(PIC_HT_IN_BLK - 1);
  localparam logic [PIX_WID-1:0] CONST_PRED = PIX_WID'(128);

  typedef enum logic [1:0] {StRow, StRowEnd, StFrameEnd} pos_e;

  logic                 out_valid_q, out_valid_d;
  logic signed [MB-1:0] y_rec_q [MEA_N];
  logic signed [MB-1:0] y_rec_d [MEA_N];
  logic [PIX_WID-1:0]   x_le_q, x_le_d;
  logic [PIX_WID-1:0]   top_q [PIC_WID_IN_BLK];
  logic [PIX_WID-1:0]   top_d [PIC_WID_IN_BLK];
  logic [CXW-1:0]       cor_x_q, cor_x_d;
  logic [CYW-1:0]       cor_y_q, cor_y_d;
  logic                 err_q, err_d;

  pos_e                 pos;
  logic                 accept, ovr;
  logic [PIX_WID-1:0]   x_pred, x_le_new, top_new;
  logic [MB-1:0]        cand0, u0, u1, u2, u3, u5, s_le, d_le, s_top, d_top;
  logic signed [MB-1:0] rec_new [MEA_N];

  assign bus.in_ready   = rst_n && (!out_valid_q || bus.out_ready);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.y_rec      = y_rec_q;
  assign bus.cor_X      = cor_x_q;
  assign bus.cor_Y      = cor_y_q;
  assign bus.frame_done = accept && (pos == StFrameEnd);
`ifdef MEAS_PRED_DEC_ERR_EN
  assign bus.err        = err_q;
`endif

  always_comb begin
    if (cor_x_q != X_LAST)      pos = StRow;
    else if (cor_y_q != Y_LAST) pos = StRowEnd;
    else                        pos = StFrameEnd;
  end

  always_comb begin
    // Neighbours missing on the picture border fall back to the constant predictor.
    ovr = (bus.code == 2'b10) || (cor_x_q == '0 && bus.code == 2'b00) ||
          (cor_y_q == '0 && bus.code == 2'b01);
    if (ovr || bus.code[1]) x_pred = CONST_PRED;
    else if (bus.code[0])   x_pred = top_q[cor_x_q];
    else                    x_pred = x_le_q;
    cand0 = MB'({x_pred, 4'b0000});

    for (int i = 0; i < MEA_N; i++) rec_new[i] = bus.y_resQ[i] <<< bus.Qstep;
    rec_new[0] = rec_new[0] + cand0;

    u0 = rec_new[0];
    u1 = rec_new[1];
    u2 = rec_new[2];
    u3 = rec_new[3];
    u5 = rec_new[5];
    s_le     = u0 + u5;
    d_le     = (s_le >> 1) - u1;
    x_le_new = PIX_WID'(d_le >> NB_SHIFT);
    s_top    = u0 + u3;
    d_top    = (s_top >> 1) - u2;
    top_new  = PIX_WID'(d_top >> NB_SHIFT);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    y_rec_d     = y_rec_q;
    x_le_d      = x_le_q;
    top_d       = top_q;
    cor_x_d     = cor_x_q;
    cor_y_d     = cor_y_q;
    err_d       = err_q;
    if (bus.out_ready) out_valid_d = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      y_rec_d     = rec_new;
      x_le_d      = x_le_new;
      // Bottom row's top values would never be read, so the buffer keeps its contents.
      if (cor_y_q != Y_LAST) top_d[cor_x_q] = top_new;
      if (ovr) err_d = 1'b1;
      unique case (pos)
        StRow:      cor_x_d = cor_x_q + 1'b1;
        StRowEnd: begin
          cor_x_d = '0;
          cor_y_d = cor_y_q + 1'b1;
        end
        StFrameEnd: begin
          cor_x_d = '0;
          cor_y_d = '0;
        end
        default: ;
      endcase
    end
    if (!rst_n) begin
      out_valid_d = 1'b0;
      y_rec_d     = '{default: '0};
      x_le_d      = '0;
      top_d       = '{default: '0};
      cor_x_d     = '0;
      cor_y_d     = '0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_valid_q <= 1'b0;
      y_rec_q     <= '{default: '0};
      x_le_q      <= '0;
      top_q       <= '{default: '0};
      cor_x_q     <= '0;
      cor_y_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      y_rec_q     <= y_rec_d;
      x_le_q      <= x_le_d;
      top_q       <= top_d;
      cor_x_q     <= cor_x_d;
      cor_y_q     <= cor_y_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_meas_pred_dec.sv
// Scoreboard bench for meas_pred_dec: an arithmetic reference model predicts each block,
// a monitor compares the DUT output whenever out_valid is presented.
module tb_meas_pred_dec;
  localparam int MEA_N = 12;
  localparam int MB    = 13;
  localparam int NBX   = 64;
  localparam int NBY   = 64;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  logic rst_n  = 1'b1;
  always #5 clk = ~clk;

  meas_pred_dec_if bus_if ();

  meas_pred_dec u_dut (
    .clk    (clk),
    .arst_n (arst_n),
    .rst_n  (rst_n),
    .bus    (bus_if)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [MEA_N*MB-1:0] exp_q [$];
  int m_cx, m_cy, m_xle;
  int m_top [NBX];
  bit m_err;
  int stim_res [MEA_N];
  int n_acc, n_fd;
  int r_code, r_q;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  function automatic int wrap(input int v);
    int m = v % 8192;
    if (m < 0) m += 8192;
    if (m >= 4096) m -= 8192;
    return m;
  endfunction

  function automatic int umod(input int v);
    int m = v % 8192;
    if (m < 0) m += 8192;
    return m;
  endfunction

  function automatic logic [MEA_N*MB-1:0] pack_rec();
    logic [MEA_N*MB-1:0] v;
    for (int i = 0; i < MEA_N; i++) v[i*MB +: MB] = bus_if.y_rec[i];
    return v;
  endfunction

  function automatic void model_reset();
    m_cx = 0;
    m_cy = 0;
    m_xle = 0;
    foreach (m_top[i]) m_top[i] = 0;
    m_err = 1'b0;
    n_acc = 0;
    exp_q.delete();
  endfunction

  // Decoder rules in plain integer arithmetic (mod 2^13 for the 13-bit buses).
  function automatic void model_accept(input int code, input int q);
    logic [MEA_N*MB-1:0] v;
    int rec [MEA_N];
    int pred, s, d;
    bit ovr;
    ovr = (code == -2) || (m_cx == 0 && code == 0) || (m_cy == 0 && code == 1);
    if (ovr || code < 0) pred = 128;
    else if (code == 0)  pred = m_xle;
    else                 pred = m_top[m_cx];
    for (int i = 0; i < MEA_N; i++) begin
      rec[i] = wrap(stim_res[i] * (1 << q) + ((i == 0) ? pred * 16 : 0));
      v[i*MB +: MB] = MB'(rec[i]);
    end
    exp_q.push_back(v);
    s = umod(umod(rec[0]) + umod(rec[5])) / 2;
    d = umod(s - umod(rec[1]));
    m_xle = (d / 8) % 256;
    if (m_cy != NBY - 1) begin
      s = umod(umod(rec[0]) + umod(rec[3])) / 2;
      d = umod(s - umod(rec[2]));
      m_top[m_cx] = (d / 8) % 256;
    end
    if (ovr) m_err = 1'b1;
    if (m_cx == NBX - 1) begin
      m_cx = 0;
      m_cy = (m_cy == NBY - 1) ? 0 : m_cy + 1;
    end else begin
      m_cx++;
    end
  endfunction

  task automatic rand_block();
    for (int i = 0; i < MEA_N; i++) stim_res[i] = int'($urandom_range(0, 8191)) - 4096;
    r_code = int'($urandom_range(0, 3)) - 2;
    r_q    = int'($urandom_range(0, 7));
  endtask

  task automatic set_res(input int idx, input int val);
    foreach (stim_res[i]) stim_res[i] = 0;
    stim_res[idx] = val;
  endtask

  task automatic step(input bit v, input int code, input int q, input bit ordy, input bit srst,
                      output bit acc);
    bit exp_fd;
    @(negedge clk);
    bus_if.in_valid  = v;
    bus_if.code      = 2'(code);
    bus_if.Qstep     = 3'(q);
    bus_if.out_ready = ordy;
    rst_n            = !srst;
    for (int i = 0; i < MEA_N; i++) bus_if.y_resQ[i] = MB'(stim_res[i]);
    #1;
    chk("out_valid", bus_if.out_valid, exp_q.size() != 0);
    if (!srst) chk("in_ready", bus_if.in_ready, (exp_q.size() == 0) || ordy);
    chk("cor_X", bus_if.cor_X, m_cx);
    chk("cor_Y", bus_if.cor_Y, m_cy);
`ifdef MEAS_PRED_DEC_ERR_EN
    chk("err", bus_if.err, m_err);
`endif
    acc = v && !srst && bus_if.in_ready;
    exp_fd = acc && m_cx == NBX - 1 && m_cy == NBY - 1;
    chk("frame_done", bus_if.frame_done, exp_fd);
    if (exp_fd) begin
      n_fd++;
      chk("frame_done_accept_no", n_acc + 1, 4096);
    end
    if (acc) begin
      n_acc = exp_fd ? 0 : n_acc + 1;
      model_accept(code, q);
    end
    if (srst) begin
      #2;
      model_reset();
    end
  endtask

  task automatic do_arst();
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    #1;
    arst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_out_valid", bus_if.out_valid, 0);
    chk("rst_cor_X", bus_if.cor_X, 0);
    chk("rst_cor_Y", bus_if.cor_Y, 0);
    chk("rst_frame_done", bus_if.frame_done, 0);
    chk("rst_y_rec_nonzero", pack_rec() != '0, 0);
    #1;
    arst_n = 1'b1;
  endtask

  // Monitor: compare every presented output against the oldest expectation.
  initial begin
    logic [MEA_N*MB-1:0] act_v;
    forever begin
      @(negedge clk);
      #2;
      if (bus_if.out_valid) begin
        act_v = pack_rec();
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL y_rec: got %h, expected no output", act_v);
        end else if (act_v == exp_q[0]) begin
          n_pass++;
        end else begin
          $display("FAIL y_rec: got %h, expected %h", act_v, exp_q[0]);
        end
        if (bus_if.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit acc;
    int guard;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    bus_if.code      = '0;
    bus_if.Qstep     = '0;
    foreach (stim_res[i]) stim_res[i] = 0;
    for (int i = 0; i < MEA_N; i++) bus_if.y_resQ[i] = '0;
    n_fd = 0;
    model_reset();
    do_arst();

    // Row 0 directed blocks.
    set_res(0, 100);
    step(1, -1, 0, 1, 0, acc);
    chk("accept_blk00", acc, 1);
    set_res(3, -5);
    step(1, 0, 2, 1, 0, acc);
    chk("blk00_y0", bus_if.y_rec[0], 2148);
    chk("blk00_y1", bus_if.y_rec[1], 0);
    set_res(0, 3);
    step(1, -2, 1, 1, 0, acc);
    chk("blk10_y0", bus_if.y_rec[0], 2144);
    chk("blk10_y3", bus_if.y_rec[3], -20);
    set_res(0, -7);
    step(1, 1, 0, 1, 0, acc);
    chk("illegal_m2_y0", bus_if.y_rec[0], 2054);
    rand_block();
    step(1, r_code, r_q, 1, 0, acc);
    chk("top_at_row0_y0", bus_if.y_rec[0], 2041);
`ifdef MEAS_PRED_DEC_ERR_EN
    chk("err_sticky", bus_if.err, 1);
`endif
    guard = 0;
    while (m_cy == 0 && guard < 200) begin
      rand_block();
      step(1, r_code, r_q, 1, 0, acc);
      guard++;
    end
    set_res(0, 0);
    step(1, 1, 0, 1, 0, acc);
    chk("wrap_accept_blk01", acc, 1);
    rand_block();
    step(1, r_code, r_q, 1, 0, acc);
    chk("blk01_top_y0", bus_if.y_rec[0], 2144);

    // Backpressure then resume.
    for (int k = 0; k < 5; k++) begin
      rand_block();
      step(1, r_code, r_q, 0, 0, acc);
      chk("bp_no_accept", acc, 0);
    end
    for (int k = 0; k < 3; k++) begin
      rand_block();
      step(1, r_code, r_q, 1, 0, acc);
      chk("bp_resume_accept", acc, 1);
    end

    // Random traffic to the end of the first frame.
    guard = 0;
    while (n_fd == 0 && guard < 20000) begin
      rand_block();
      step($urandom_range(0, 9) < 8, r_code, r_q, $urandom_range(0, 9) < 8, 0, acc);
      guard++;
    end
    chk("frame_done_once", n_fd, 1);

    // Synchronous clear with a held output.
    for (int k = 0; k < 20; k++) begin
      rand_block();
      step(1, r_code, r_q, 1, 0, acc);
    end
    rand_block();
    step(1, r_code, r_q, 0, 1, acc);
    chk("srst_no_accept", acc, 0);
    for (int k = 0; k < 300; k++) begin
      rand_block();
      step($urandom_range(0, 9) < 7, r_code, r_q, $urandom_range(0, 9) < 7, 0, acc);
    end

    do_arst();
    for (int k = 0; k < 150; k++) begin
      rand_block();
      step($urandom_range(0, 9) < 8, r_code, r_q, $urandom_range(0, 9) < 8, 0, acc);
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      step(0, 0, 0, 1, 0, acc);
      guard++;
    end
    chk("drain_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
